// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared definitions for the decoder family (decoder_generic,
//   priority_encoder_queued).
//   - lines(n)   : number of one-hot lines for an n-bit code (2**n).
//   - onehot_bit : bit k of the one-hot expansion of idx. Callers build
//                  full one-hot vectors with a generate or for loop, so
//                  the vector width always matches the caller's own line
//                  count.
package decoder_pkg;

  localparam int N_DEFAULT = 4;

  function automatic int lines(input int n);
    return 2 ** n;
  endfunction

  function automatic logic onehot_bit(input int idx, input int k);
    return (idx == k);
  endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// lsb_priority_enc
//   Combinational lowest-index-first priority encoder.
//   Ports:
//     req_i [0:2**n-1] : request vector. req_i[0] is index 0 (leftmost).
//     idx_o [n-1:0]    : lowest k with req_i[k]=1. It is 0 when none is set.
//     any_o            : OR of all request bits.
module lsb_priority_enc
  import decoder_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic [0:lines(n)-1] req_i,
  output logic [n-1:0]        idx_o,
  output logic                any_o
);

  localparam int L = lines(n);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    idx_o = '0;
    for (int k = L - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = n'(k);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/priority_encoder_queued.sv
// priority_encoder_queued
//   Collects multi-hot request lines into a pending register. It hands out
//   their binary indices one per cycle, lowest index first, over a
//   valid/ready handshake.
//   Ports:
//     clk, rst_n        : clock, async active-low reset
//     en                : capture enable for w
//     w   [0:2**n-1]    : request lines (w[0] = index 0)
//     clr               : synchronous clear. It overrides capture and serve.
//     ready             : consumer takes y this cycle
//     valid             : some request is pending
//     y   [n-1:0]       : lowest pending index (0 when empty)
//     pending [0:2**n-1]: pending request register
//     cnt [n:0]         : popcount of pending
//     dup               : registered one-cycle duplicate-request pulse
//   valid, y and cnt depend only on the pending register. No input reaches
//   an output combinationally.
module priority_encoder_queued
  import decoder_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [0:lines(n)-1] w,
  input  logic                clr,
  input  logic                ready,
  output logic                valid,
  output logic [n-1:0]        y,
  output logic [0:lines(n)-1] pending,
  output logic [n:0]          cnt,
  output logic                dup
);

  localparam int L = lines(n);

  logic [0:L-1] pending_q, pending_d;
  logic         dup_q, dup_d;
  logic [0:L-1] served_mask;
  logic [n-1:0] enc_idx;
  logic         enc_any;
  logic         serve;

  lsb_priority_enc #(.n(n)) u_enc (
    .req_i (pending_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // ready with nothing pending is ignored: serve needs a pending bit.
  assign serve = enc_any & ready;

  always_comb begin
    served_mask = '0;
    for (int k = 0; k < L; k++) begin
      served_mask[k] = serve & onehot_bit(32'(enc_idx), k);
    end
  end

  // The clear is applied before the set, so a same-cycle re-request of
  // the served index keeps it pending. A re-request of the bit being
  // served does not count as a duplicate.
  always_comb begin
    pending_d = pending_q;
    dup_d     = 1'b0;
    if (clr) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q & ~served_mask) | (en ? w : '0);
      dup_d     = en & (|(w & pending_q & ~served_mask));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      dup_q     <= dup_d;
    end
  end

  // Population count as a loop-summed adder.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < L; k++) begin
      cnt = cnt + (n + 1)'(pending_q[k]);
    end
  end

  assign valid   = enc_any;
  assign y       = enc_idx;
  assign pending = pending_q;
  assign dup     = dup_q;

endmodule

// File: tb/tb_priority_encoder_queued.sv
module tb_priority_encoder_queued;

  localparam int N = 4;
  localparam int L = 16;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [0:L-1]  w;
  logic          clr;
  logic          ready;
  logic          valid;
  logic [N-1:0]  y;
  logic [0:L-1]  pending;
  logic [N:0]    cnt;
  logic          dup;

  int checks   = 0;
  int failures = 0;

  // Reference model: a set of pending indices as a bit array, plus the dup flag.
  bit [0:L-1] mp;
  bit         mdup;

  priority_encoder_queued #(.n(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .w       (w),
    .clr     (clr),
    .ready   (ready),
    .valid   (valid),
    .y       (y),
    .pending (pending),
    .cnt     (cnt),
    .dup     (dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int low_idx(input bit [0:L-1] p);
    for (int k = 0; k < L; k++) if (p[k]) return k;
    return 0;
  endfunction

  function automatic bit [0:L-1] bit_at(input int k);
    bit [0:L-1] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // One clock edge applied to the model, using the spec's next-state rules.
  task automatic model_edge();
    bit [0:L-1] sm;
    bit [0:L-1] wv;
    sm = '0;
    wv = w;
    if (clr) begin
      mp   = '0;
      mdup = 1'b0;
    end else begin
      if ((mp != 0) && ready) sm[low_idx(mp)] = 1'b1;
      mdup = en && ((wv & mp & ~sm) != 0);
      mp   = (mp & ~sm) | (en ? wv : '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; w = '0; clr = 1'b0; ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    mp = '0; mdup = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (y !== '0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (dup !== 1'b0) begin failures++; $display("FAIL reset_dup got=%b exp=0", dup); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    en = 1'b1; w = 16'b0010_0000_0000_0000;
    tick();
    idle_inputs();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%b exp=1", valid); end
    checks++; if (y !== 4'd2) begin failures++; $display("FAIL cap_y got=%0d exp=2", y); end
    checks++; if (cnt !== 5'd1) begin failures++; $display("FAIL cap_cnt got=%0d exp=1", cnt); end
    checks++; if (dup !== 1'b0) begin failures++; $display("FAIL cap_dup got=%b exp=0", dup); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_drain();
    int exp_seq[3] = '{3, 7, 12};
    en = 1'b1; w = bit_at(3) | bit_at(7) | bit_at(12);
    tick();
    en = 1'b0; w = '0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (y !== N'(exp_seq[i]) || valid !== 1'b1) begin
        failures++; $display("FAIL drain_y[%0d] got=%0d/v%b exp=%0d/v1", i, y, valid, exp_seq[i]);
      end
      checks++;
      if (cnt !== (N + 1)'(3 - i)) begin failures++; $display("FAIL drain_cnt[%0d] got=%0d exp=%0d", i, cnt, 3 - i); end
      tick();
    end
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL drain_empty_valid got=%b exp=0", valid); end
    checks++; if (y !== '0) begin failures++; $display("FAIL drain_empty_y got=%0d exp=0", y); end
    checks++; if (cnt !== '0) begin failures++; $display("FAIL drain_empty_cnt got=%0d exp=0", cnt); end
    // ready while empty does nothing.
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (valid !== 1'b0 || cnt !== '0) begin failures++; $display("FAIL empty_ready got=v%b c%0d exp=v0 c0", valid, cnt); end
  endtask

  task automatic test_serve_set();
    en = 1'b1; w = bit_at(5);
    tick();
    ready = 1'b1; en = 1'b1; w = bit_at(5);
    tick();
    idle_inputs();
    checks++; if (pending !== bit_at(5)) begin failures++; $display("FAIL srvset_pending got=%h exp=%h", pending, bit_at(5)); end
    checks++; if (cnt !== 5'd1) begin failures++; $display("FAIL srvset_cnt got=%0d exp=1", cnt); end
    checks++; if (dup !== 1'b0) begin failures++; $display("FAIL srvset_dup got=%b exp=0", dup); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_dup_full();
    en = 1'b1; w = '1; ready = 1'b0;
    tick();
    checks++; if (cnt !== 5'd16) begin failures++; $display("FAIL full_cnt got=%0d exp=16", cnt); end
    checks++; if (dup !== 1'b0) begin failures++; $display("FAIL full_dup_first got=%b exp=0", dup); end
    tick();
    en = 1'b0; w = '0;
    checks++; if (dup !== 1'b1) begin failures++; $display("FAIL full_dup_second got=%b exp=1", dup); end
    checks++; if (cnt !== 5'd16) begin failures++; $display("FAIL full_cnt_hold got=%0d exp=16", cnt); end
    tick();
    checks++; if (dup !== 1'b0) begin failures++; $display("FAIL dup_pulse_len got=%b exp=0", dup); end
  endtask

  task automatic test_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; w = bit_at(1) | bit_at(9);
    tick();
    clr = 1'b1; en = 1'b1; w = bit_at(4); ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (pending !== '0) begin failures++; $display("FAIL clr_pending got=%h exp=0", pending); end
    checks++; if (valid !== 1'b0 || cnt !== '0) begin failures++; $display("FAIL clr_valid_cnt got=v%b c%0d exp=v0 c0", valid, cnt); end
    checks++; if (dup !== 1'b0) begin failures++; $display("FAIL clr_dup got=%b exp=0", dup); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; w = bit_at(2) | bit_at(6) | bit_at(11);
    tick();
    idle_inputs();
    ready = 1'b1;
    tick();
    // Now 3 ns past the edge: drop reset well away from any clock edge.
    #2;
    rst_n = 1'b0;
    mp = '0; mdup = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || y !== '0 || cnt !== '0 || dup !== 1'b0 || pending !== '0) begin
      failures++; $display("FAIL async_rst got=v%b y%0d c%0d d%b exp=all 0", valid, y, cnt, dup);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b0;
    en = 1'b1; w = bit_at(14);
    tick();
    idle_inputs();
    checks++; if (valid !== 1'b1 || y !== 4'd14 || cnt !== 5'd1) begin
      failures++; $display("FAIL post_rst_cap got=v%b y%0d c%0d exp=v1 y14 c1", valid, y, cnt);
    end
  endtask

  task automatic test_random();
    clr = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 2) == 0);
      w     = 16'($urandom) & 16'($urandom) & 16'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 40) == 0);
      tick();
      checks++; if (pending !== mp) begin failures++; $display("FAIL rnd_pending[%0d] got=%h exp=%h", i, pending, mp); end
      checks++; if (valid !== (mp != 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, valid, (mp != 0)); end
      checks++; if (y !== N'(low_idx(mp))) begin failures++; $display("FAIL rnd_y[%0d] got=%0d exp=%0d", i, y, low_idx(mp)); end
      checks++; if (cnt !== (N + 1)'($countones(mp))) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, cnt, $countones(mp)); end
      checks++; if (dup !== mdup) begin failures++; $display("FAIL rnd_dup[%0d] got=%b exp=%b", i, dup, mdup); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_capture();
    test_drain();
    test_serve_set();
    test_dup_full();
    test_clr();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
